// File: rtl/pcie_ltssm_pkg.sv
// Shared LTSSM definitions: interval timer codes, PIPE PowerDown encodings,
// RxStatus codes and the Detect substate enum used by the Detect controller.
package pcie_ltssm_pkg;

    // Interval timer codes understood by the LTSSM interval timer
    localparam logic [2:0] T0MS  = 3'b000;
    localparam logic [2:0] T12MS = 3'b001;
    localparam logic [2:0] T24MS = 3'b010;
    localparam logic [2:0] T48MS = 3'b011;
    localparam logic [2:0] T2MS  = 3'b100;
    localparam logic [2:0] T8MS  = 3'b101;

    // PIPE PowerDown encodings
    localparam logic [1:0] PD_P0  = 2'b00;
    localparam logic [1:0] PD_P0S = 2'b01;
    localparam logic [1:0] PD_P1  = 2'b10;
    localparam logic [1:0] PD_P2  = 2'b11;

    // PIPE RxStatus codes relevant to receiver detection
    localparam logic [2:0] RXSTAT_OK         = 3'b000;
    localparam logic [2:0] RXSTAT_RX_PRESENT = 3'b011;

    typedef enum logic [3:0] {
        DET_IDLE    = 4'd0,
        DET_Q_START = 4'd1,
        DET_QUIET   = 4'd2,
        DET_A_START = 4'd3,
        DET_ACTIVE  = 4'd4,
        DET_EVAL    = 4'd5,
        DET_R_START = 4'd6,
        DET_RWAIT   = 4'd7,
        DET_DONE    = 4'd8,
        DET_HOLD    = 4'd9
    } detect_state_t;

    // Interval code the timer should see while the controller sits in a state.
    // The code is held through the whole interval, not only on the start pulse.
    function automatic logic [2:0] interval_for(detect_state_t s);
        case (s)
            DET_Q_START, DET_QUIET, DET_R_START, DET_RWAIT: return T12MS;
            DET_A_START, DET_ACTIVE:                        return T2MS;
            default:                                        return T0MS;
        endcase
    endfunction

endpackage

// File: rtl/rx_detect_lane_capture.sv
// Per-lane receiver-detect capture: remembers whether the lane has returned
// PhyStatus during Detect.Active and whether its RxStatus reported a receiver.
// Only the first PhyStatus after a clear is taken; repeats are ignored.
module rx_detect_lane_capture
    import pcie_ltssm_pkg::*;
(
    input  logic       Pclk,
    input  logic       Reset,
    input  logic       clear,
    input  logic       capture,
    input  logic       phy_status,
    input  logic [2:0] rx_status,
    output logic       seen,
    output logic       result
);

    // Seen/result flop pair, cleared at the start of every active attempt
    always_ff @(posedge Pclk) begin
        if (!Reset) begin
            seen   <= 1'b0;
            result <= 1'b0;
        end else if (clear) begin
            seen   <= 1'b0;
            result <= 1'b0;
        end else if (capture && phy_status && !seen) begin
            seen   <= 1'b1;
            result <= (rx_status == RXSTAT_RX_PRESENT);
        end
    end

endmodule

// File: rtl/detect_substate_ctrl.sv
// LTSSM Detect controller (Detect.Quiet / Detect.Active).
// Sequences the interval timer, requests PIPE receiver detection on all lanes,
// retries once on a partial result and reports the detected-lane mask.
// Optional build macro DETECT_ATTEMPT_CNT_EN adds the DetectAttempts counter.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | not in Detect, timer held cleared
// Q_START   | start 12ms quiet interval
// QUIET     | Detect.Quiet, wait timeout or electrical-idle exit
// A_START   | start 2ms guard, clear per-lane capture
// ACTIVE    | TxDetectRx asserted, collect PhyStatus/RxStatus per lane
// EVAL      | decide: done, retry after 12ms, or back to quiet
// R_START   | start 12ms retry wait
// RWAIT     | wait before the second active attempt
// DONE      | one-cycle DetectDone, latch lane mask
// HOLD      | keep mask until Enable drops
module detect_substate_ctrl
    import pcie_ltssm_pkg::*;
#(
    parameter int         LANES   = 4,
    parameter logic [1:0] P1_CODE = 2'b10
) (
    input  logic               Pclk,
    input  logic               Reset,
    input  logic               Enable,
    input  logic               TimeOut,
    input  logic [LANES-1:0]   PhyStatus,
    input  logic [3*LANES-1:0] RxStatus,
    input  logic [LANES-1:0]   RxElecIdle,
    output logic               TimerStart,
    output logic               TimerEnable,
    output logic [2:0]         TimerIntervalCode,
    output logic               TxDetectRx,
    output logic [LANES-1:0]   TxElecIdle,
    output logic [1:0]         PowerDown,
    output logic               DetectDone,
    output logic [LANES-1:0]   DetectedLanes
`ifdef DETECT_ATTEMPT_CNT_EN
    ,
    output logic [7:0]         DetectAttempts
`endif
);

    detect_state_t    state;
    detect_state_t    state_next;
    logic             att2;
    logic             att2_next;
    logic [LANES-1:0] first;
    logic [LANES-1:0] first_next;
    logic [LANES-1:0] seen;
    logic [LANES-1:0] result;
    logic             lane_clear;
    logic             lane_capture;
    logic             all_seen;
    logic             timeout_ok;

    // The timer forces TimeOut low while it is being restarted; gate anyway
    // so a stale TimeOut can never end a freshly started interval.
    assign timeout_ok = TimeOut && !TimerStart;

    // A lane pulsing PhyStatus this cycle counts as seen, so the exit to EVAL
    // and the final capture land on the same edge.
    assign all_seen = &(seen | PhyStatus);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        rx_detect_lane_capture u_capture (
            .Pclk       (Pclk),
            .Reset      (Reset),
            .clear      (lane_clear),
            .capture    (lane_capture),
            .phy_status (PhyStatus[i]),
            .rx_status  (RxStatus[3*i +: 3]),
            .seen       (seen[i]),
            .result     (result[i])
        );
    end

    // Next-state, retry bookkeeping and lane-capture control
    always_comb begin
        state_next   = state;
        att2_next    = att2;
        first_next   = first;
        lane_clear   = 1'b0;
        lane_capture = 1'b0;
        if (state != DET_IDLE && !Enable) begin
            state_next = DET_IDLE;
            att2_next  = 1'b0;
        end else begin
            case (state)
                DET_IDLE: begin
                    att2_next = 1'b0;
                    if (Enable) state_next = DET_Q_START;
                end
                DET_Q_START: state_next = DET_QUIET;
                DET_QUIET: begin
                    if (timeout_ok || !(&RxElecIdle)) state_next = DET_A_START;
                end
                DET_A_START: begin
                    lane_clear = 1'b1;
                    state_next = DET_ACTIVE;
                end
                DET_ACTIVE: begin
                    lane_capture = 1'b1;
                    if (all_seen || timeout_ok) state_next = DET_EVAL;
                end
                DET_EVAL: begin
                    if (result == '0) begin
                        state_next = DET_Q_START;
                        att2_next  = 1'b0;
                    end else if (&result) begin
                        state_next = DET_DONE;
                    end else if (!att2) begin
                        first_next = result;
                        att2_next  = 1'b1;
                        state_next = DET_R_START;
                    end else if (result == first) begin
                        state_next = DET_DONE;
                    end else begin
                        state_next = DET_Q_START;
                        att2_next  = 1'b0;
                    end
                end
                DET_R_START: state_next = DET_RWAIT;
                DET_RWAIT: begin
                    if (timeout_ok) state_next = DET_A_START;
                end
                DET_DONE: state_next = DET_HOLD;
                DET_HOLD: state_next = DET_HOLD;
                default:  state_next = DET_IDLE;
            endcase
        end
    end

    // State register plus registered outputs decoded from the next state
    always_ff @(posedge Pclk) begin
        if (!Reset) begin
            state             <= DET_IDLE;
            att2              <= 1'b0;
            first             <= '0;
            TimerStart        <= 1'b1;
            TimerEnable       <= 1'b0;
            TimerIntervalCode <= T0MS;
            TxDetectRx        <= 1'b0;
            TxElecIdle        <= '1;
            PowerDown         <= P1_CODE;
            DetectDone        <= 1'b0;
            DetectedLanes     <= '0;
        end else begin
            state             <= state_next;
            att2              <= att2_next;
            first             <= first_next;
            TimerStart        <= !(state_next inside {DET_QUIET, DET_ACTIVE, DET_RWAIT});
            TimerEnable       <= (state_next inside {DET_QUIET, DET_ACTIVE, DET_RWAIT});
            TimerIntervalCode <= interval_for(state_next);
            TxDetectRx        <= (state_next == DET_ACTIVE);
            TxElecIdle        <= '1;
            PowerDown         <= P1_CODE;
            DetectDone        <= (state_next == DET_DONE);
            if (state_next == DET_DONE) begin
                DetectedLanes <= result;
            end else if (state_next == DET_IDLE) begin
                DetectedLanes <= '0;
            end
        end
    end

`ifdef DETECT_ATTEMPT_CNT_EN
    // Saturating count of active attempts since leaving IDLE
    always_ff @(posedge Pclk) begin
        if (!Reset) begin
            DetectAttempts <= 8'd0;
        end else if (state_next == DET_IDLE) begin
            DetectAttempts <= 8'd0;
        end else if (state_next == DET_A_START && DetectAttempts != 8'hFF) begin
            DetectAttempts <= DetectAttempts + 8'd1;
        end
    end
`endif

endmodule
